// File: rtl/mem_ctrl_multiport.sv
// mem_ctrl_multiport
// Byte-serial RAM controller that arbitrates NUM_CH requesters onto a single
// 8-bit RAM port. Each granted request moves 1/2/4/8 bytes little-endian.
// The byte count is clamped to DATA_W/8, and read data is zero-extended.
// Completion is a one-cycle rsp_valid pulse to the owning channel, two
// cycles after the last byte address was driven.
//
// Ports
//   clk_in     rising-edge clock
//   rst_n_in   asynchronous active-low reset
//   rdy_in     global enable; low freezes every register (RAM co-stalls)
//   req_valid  per-channel request strobe
//   req_we     per-channel write (1) / read (0)
//   req_addr   per-channel start byte address, ch i at [i*ADDR_W +: ADDR_W]
//   req_size   per-channel log2 byte count
//   req_wdata  per-channel write data, byte 0 in bits [7:0]
//   flush_in   per-channel cancel of a pending or in-flight read
//   req_ready  one-hot grant (combinational, IDLE only)
//   rsp_valid  one-cycle completion pulse to the owning channel
//   rsp_rdata  shared read result, valid with rsp_valid
//   busy_out   transaction in progress
//   ram_addr   RAM byte address
//   ram_wr     RAM write strobe
//   ram_dout   RAM write byte
//   ram_din    RAM read byte, one cycle after ram_addr
module mem_ctrl_multiport #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int NUM_CH = 2,
    parameter int ARB_RR = 0
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    input  logic                     rdy_in,
    input  logic [NUM_CH-1:0]        req_valid,
    input  logic [NUM_CH-1:0]        req_we,
    input  logic [NUM_CH*ADDR_W-1:0] req_addr,
    input  logic [NUM_CH*2-1:0]      req_size,
    input  logic [NUM_CH*DATA_W-1:0] req_wdata,
    input  logic [NUM_CH-1:0]        flush_in,
    output logic [NUM_CH-1:0]        req_ready,
    output logic [NUM_CH-1:0]        rsp_valid,
    output logic [DATA_W-1:0]        rsp_rdata,
    output logic                     busy_out,
    output logic [ADDR_W-1:0]        ram_addr,
    output logic                     ram_wr,
    output logic [7:0]               ram_dout,
    input  logic [7:0]               ram_din
);

    localparam int NB    = DATA_W / 8;
    localparam int CNT_W = (NB > 1) ? $clog2(NB) : 1;
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_TAIL = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_s;

    logic [NUM_CH-1:0]   eligible_s;
    logic [NUM_CH-1:0]   grant_s;
    logic [CH_W-1:0]     grant_idx_s;
    logic                found_s;
    logic                hs_s;

    logic                sel_we_s;
    logic [ADDR_W-1:0]   sel_addr_s;
    logic [1:0]          sel_size_s;
    logic [DATA_W-1:0]   sel_wdata_s;
    logic [3:0]          sel_n_s;
    logic [CNT_W-1:0]    sel_last_s;

    logic [CH_W-1:0]     ch_r;
    logic                we_r;
    logic [CNT_W-1:0]    last_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [DATA_W-1:0]   wdata_r;
    logic [DATA_W-1:0]   rdata_r;
    logic                flushed_r;
    logic [CH_W-1:0]     last_grant_r;

    logic [ADDR_W-1:0]   ram_addr_r;
    logic                ram_wr_r;
    logic [7:0]          ram_dout_r;
    logic [NUM_CH-1:0]   rsp_valid_r;
    logic                rsp_read_r;
    logic [DATA_W-1:0]   rsp_rdata_r;

    logic                cap_en_s;
    logic [CNT_W-1:0]    cap_idx_s;
    logic [DATA_W-1:0]   rdata_cap_s;
    logic                kill_s;
    logic [NUM_CH-1:0]   ch_onehot_s;

    // Arbiter: scan from the start index (0 for fixed priority, one past the
    // last grant for round-robin) and take the first eligible channel.
    always_comb begin
        int start_v;
        int idx_v;
        logic hit_v;
        eligible_s  = req_valid & ~flush_in;
        grant_idx_s = '0;
        found_s     = 1'b0;
        start_v     = (ARB_RR != 0) ? ((int'(last_grant_r) + 1) % NUM_CH) : 0;
        for (int off = 0; off < NUM_CH; off++) begin
            idx_v       = (start_v + off) % NUM_CH;
            hit_v       = eligible_s[CH_W'(idx_v)] && !found_s;
            grant_idx_s = hit_v ? CH_W'(idx_v) : grant_idx_s;
            found_s     = found_s | hit_v;
        end
        hs_s = (state_r == ST_IDLE) && rdy_in && found_s;
        for (int i = 0; i < NUM_CH; i++) begin
            grant_s[i] = hs_s && (grant_idx_s == CH_W'(i));
        end
    end

    assign req_ready = grant_s;

    // Request fields of the winning channel, byte count clamped to DATA_W/8.
    always_comb begin
        sel_we_s    = req_we[grant_idx_s];
        sel_addr_s  = req_addr[grant_idx_s * ADDR_W +: ADDR_W];
        sel_size_s  = req_size[grant_idx_s * 2 +: 2];
        sel_wdata_s = req_wdata[grant_idx_s * DATA_W +: DATA_W];
        case (sel_size_s)
            2'd0:    sel_n_s = 4'd1;
            2'd1:    sel_n_s = 4'd2;
            2'd2:    sel_n_s = 4'd4;
            2'd3:    sel_n_s = 4'd8;
            default: sel_n_s = 4'd1;
        endcase
        if (int'(sel_n_s) > NB) begin
            sel_n_s = 4'(NB);
        end else begin
            sel_n_s = sel_n_s;
        end
        sel_last_s = CNT_W'(sel_n_s - 4'd1);
    end

    // Read capture: byte k arrives one cycle after its address, so XFER step k
    // stores byte k-1 and TAIL stores the final byte.
    always_comb begin
        cap_en_s    = rdy_in && !we_r &&
                      (((state_r == ST_XFER) && (cnt_r != '0)) || (state_r == ST_TAIL));
        cap_idx_s   = (state_r == ST_TAIL) ? last_r : (cnt_r - CNT_W'(1));
        rdata_cap_s = rdata_r;
        if (cap_en_s) begin
            rdata_cap_s[{cap_idx_s, 3'b000} +: 8] = ram_din;
        end else begin
            rdata_cap_s = rdata_r;
        end
        kill_s = !we_r && (flushed_r || flush_in[ch_r]);
        for (int i = 0; i < NUM_CH; i++) begin
            ch_onehot_s[i] = (ch_r == CH_W'(i));
        end
    end

    // Next-state logic; a low rdy_in freezes the sequence in place.
    always_comb begin
        state_s = state_r;
        if (!rdy_in) begin
            state_s = state_r;
        end else begin
            case (state_r)
                ST_IDLE: state_s = hs_s ? ST_XFER : ST_IDLE;
                ST_XFER: state_s = (cnt_r == last_r) ? ST_TAIL : ST_XFER;
                ST_TAIL: state_s = ST_IDLE;
                default: state_s = ST_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath: request latch, byte sequencing, completion and RR pointer.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            ch_r         <= '0;
            we_r         <= 1'b0;
            last_r       <= '0;
            cnt_r        <= '0;
            wdata_r      <= '0;
            rdata_r      <= '0;
            flushed_r    <= 1'b0;
            last_grant_r <= CH_W'(NUM_CH - 1);
            ram_addr_r   <= '0;
            ram_wr_r     <= 1'b0;
            ram_dout_r   <= 8'h00;
            rsp_valid_r  <= '0;
            rsp_read_r   <= 1'b0;
            rsp_rdata_r  <= '0;
        end else if (rdy_in) begin
            rsp_valid_r <= '0;
            rdata_r     <= rdata_cap_s;
            case (state_r)
                ST_IDLE: begin
                    if (hs_s) begin
                        ch_r         <= grant_idx_s;
                        we_r         <= sel_we_s;
                        last_r       <= sel_last_s;
                        cnt_r        <= '0;
                        ram_addr_r   <= sel_addr_s;
                        ram_wr_r     <= sel_we_s;
                        ram_dout_r   <= sel_we_s ? sel_wdata_s[7:0] : 8'h00;
                        wdata_r      <= sel_wdata_s >> 8;
                        rdata_r      <= '0;
                        flushed_r    <= 1'b0;
                        last_grant_r <= grant_idx_s;
                    end
                end
                ST_XFER: begin
                    flushed_r <= flushed_r | (!we_r && flush_in[ch_r]);
                    if (cnt_r == last_r) begin
                        ram_wr_r <= 1'b0;
                    end else begin
                        cnt_r      <= cnt_r + CNT_W'(1);
                        ram_addr_r <= ram_addr_r + ADDR_W'(1);
                        ram_dout_r <= we_r ? wdata_r[7:0] : 8'h00;
                        wdata_r    <= wdata_r >> 8;
                    end
                end
                ST_TAIL: begin
                    rsp_valid_r <= kill_s ? '0 : ch_onehot_s;
                    rsp_read_r  <= !we_r;
                    rsp_rdata_r <= we_r ? '0 : rdata_cap_s;
                    flushed_r   <= 1'b0;
                end
                default: begin
                    rsp_valid_r <= '0;
                end
            endcase
        end
    end

    // A flush arriving in the completion cycle still cancels a read pulse.
    assign rsp_valid = rsp_valid_r & ~(flush_in & {NUM_CH{rsp_read_r}});
    assign rsp_rdata = rsp_rdata_r;
    assign busy_out  = (state_r != ST_IDLE);
    assign ram_addr  = ram_addr_r;
    assign ram_wr    = ram_wr_r;
    assign ram_dout  = ram_dout_r;

endmodule

// File: tb/tb_mem_ctrl_multiport.sv
module tb_mem_ctrl_multiport;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NC = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              rdy;
    logic [NC-1:0]     req_valid;
    logic [NC-1:0]     req_we;
    logic [NC*AW-1:0]  req_addr;
    logic [NC*2-1:0]   req_size;
    logic [NC*DW-1:0]  req_wdata;
    logic [NC-1:0]     flush;

    logic [NC-1:0]     ready0, rsp_valid0, ready1, rsp_valid1;
    logic [DW-1:0]     rdata0, rdata1;
    logic              busy0, busy1, ram_wr0, ram_wr1;
    logic [AW-1:0]     ram_addr0, ram_addr1;
    logic [7:0]        ram_dout0, ram_dout1;
    logic [7:0]        ram_din0;
    logic [7:0]        ram_din1;

    int n_chk = 0;
    int n_fail = 0;

    // Simple byte RAM on address bits [8:0], co-stalled with rdy.
    logic [7:0] mem [0:511];
    logic       load_en;
    logic [8:0] load_idx;
    logic [7:0] load_data;

    always #5 clk = ~clk;

    assign ram_din1 = 8'h00;

    always @(posedge clk) begin
        if (load_en) mem[load_idx] <= load_data;
        if (rdy) begin
            if (ram_wr0) mem[ram_addr0[8:0]] <= ram_dout0;
            ram_din0 <= mem[ram_addr0[8:0]];
        end
    end

    mem_ctrl_multiport #(.ADDR_W(AW), .DATA_W(DW), .NUM_CH(NC), .ARB_RR(0)) dut (
        .clk_in(clk), .rst_n_in(rst_n), .rdy_in(rdy),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
        .req_size(req_size), .req_wdata(req_wdata), .flush_in(flush),
        .req_ready(ready0), .rsp_valid(rsp_valid0), .rsp_rdata(rdata0),
        .busy_out(busy0), .ram_addr(ram_addr0), .ram_wr(ram_wr0),
        .ram_dout(ram_dout0), .ram_din(ram_din0)
    );

    mem_ctrl_multiport #(.ADDR_W(AW), .DATA_W(DW), .NUM_CH(NC), .ARB_RR(1)) dut_rr (
        .clk_in(clk), .rst_n_in(rst_n), .rdy_in(rdy),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
        .req_size(req_size), .req_wdata(req_wdata), .flush_in(flush),
        .req_ready(ready1), .rsp_valid(rsp_valid1), .rsp_rdata(rdata1),
        .busy_out(busy1), .ram_addr(ram_addr1), .ram_wr(ram_wr1),
        .ram_dout(ram_dout1), .ram_din(ram_din1)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [8:0] idx, input logic [7:0] data);
        @(negedge clk);
        load_en   = 1'b1;
        load_idx  = idx;
        load_data = data;
        @(negedge clk);
        load_en   = 1'b0;
    endtask

    task automatic set_req(input int ch, input logic v, input logic we,
                           input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
        req_valid[ch]          = v;
        req_we[ch]             = we;
        req_addr[ch*AW +: AW]  = a;
        req_size[ch*2 +: 2]    = sz;
        req_wdata[ch*DW +: DW] = wd;
    endtask

    // One complete transaction on an otherwise idle controller; n is the
    // expected byte count after clamping.
    task automatic run_txn(input string tag, input int ch, input logic we, input logic [31:0] a,
                           input logic [1:0] sz, input int n, input logic [31:0] wd,
                           input logic [31:0] exp_rdata);
        logic [31:0] ea;
        @(negedge clk);
        set_req(ch, 1'b1, we, a, sz, wd);
        #1 check({tag, " ready"}, 64'(ready0), 64'(2'b01 << ch));
        @(negedge clk);
        req_valid = '0;
        for (int k = 0; k < n; k++) begin
            if (k > 0) @(negedge clk);
            ea = a + 32'(k);
            check({tag, " addr"}, 64'(ram_addr0), 64'(ea));
            check({tag, " wr"}, 64'(ram_wr0), 64'(we));
            if (we) check({tag, " dout"}, 64'(ram_dout0), 64'(wd[8*k +: 8]));
            if (k == 0) check({tag, " busy"}, 64'(busy0), 64'd1);
        end
        @(negedge clk);
        check({tag, " tail wr"}, 64'(ram_wr0), 64'd0);
        check({tag, " tail rsp"}, 64'(rsp_valid0), 64'd0);
        @(negedge clk);
        check({tag, " rsp"}, 64'(rsp_valid0), 64'(2'b01 << ch));
        check({tag, " done wr"}, 64'(ram_wr0), 64'd0);
        if (!we) check({tag, " rdata"}, 64'(rdata0), 64'(exp_rdata));
    endtask

    logic [1:0]  rr_exp   [5] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
    logic [31:0] stall_ad [7] = '{32'h100, 32'h101, 32'h101, 32'h101, 32'h101, 32'h102, 32'h103};

    initial begin
        rst_n = 1'b0; rdy = 1'b1;
        req_valid = '0; req_we = '0; req_addr = '0; req_size = '0; req_wdata = '0; flush = '0;
        load_en = 1'b0; load_idx = '0; load_data = '0;

        // RAM preload while the controller is held in reset
        load(9'h100, 8'h11); load(9'h101, 8'h22); load(9'h102, 8'h33); load(9'h103, 8'h44);
        load(9'h1FF, 8'h5A); load(9'h000, 8'hA5);
        #1;
        check("rst ram_addr", 64'(ram_addr0), 64'd0);
        check("rst ram_wr", 64'(ram_wr0), 64'd0);
        check("rst ram_dout", 64'(ram_dout0), 64'd0);
        check("rst rsp_valid", 64'(rsp_valid0), 64'd0);
        check("rst rdata", 64'(rdata0), 64'd0);
        check("rst busy", 64'(busy0), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_txn("rd4", 0, 1'b0, 32'h100, 2'd2, 4, 32'h0, 32'h44332211);
        run_txn("wr2", 0, 1'b1, 32'h20, 2'd1, 2, 32'hA1B2C3D4, 32'h0);
        run_txn("rdback", 0, 1'b0, 32'h20, 2'd1, 2, 32'h0, 32'h0000C3D4);
        run_txn("clamp8", 0, 1'b0, 32'h100, 2'd3, 4, 32'h0, 32'h44332211);
        @(negedge clk);
        run_txn("wrap", 1, 1'b0, 32'hFFFFFFFF, 2'd1, 2, 32'h0, 32'h0000A55A);

        // Arbitration: both channels request 1B reads continuously
        @(negedge clk);
        set_req(0, 1'b1, 1'b0, 32'h100, 2'd0, 32'h0);
        set_req(1, 1'b1, 1'b0, 32'h101, 2'd0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            #1;
            check("arb fixed", 64'(ready0), 64'(2'b01));
            check("arb rr", 64'(ready1), 64'(rr_exp[i]));
            @(negedge clk);
            #1 check("arb busy ready", 64'(ready0), 64'd0);
            if (i == 4) req_valid = '0;
            @(negedge clk);
            @(negedge clk);
        end

        // Flush of an in-flight ch1 read; waiting ch0 wins at T+6
        @(negedge clk);
        set_req(1, 1'b1, 1'b0, 32'h100, 2'd2, 32'h0);
        #1 check("fl grant1", 64'(ready0), 64'(2'b10));
        @(negedge clk);
        req_valid = '0;
        set_req(0, 1'b1, 1'b0, 32'h20, 2'd0, 32'h0);
        #1 check("fl busy ready", 64'(ready0), 64'd0);
        @(negedge clk);
        flush = 2'b10;
        @(negedge clk);
        flush = 2'b00;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        #1 check("fl no rsp", 64'(rsp_valid0), 64'd0);
        check("fl grant0", 64'(ready0), 64'(2'b01));
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        check("fl ch0 rsp", 64'(rsp_valid0), 64'(2'b01));
        check("fl ch0 rdata", 64'(rdata0), 64'h000000D4);

        // Flush in the completion cycle of a ch0 read
        @(negedge clk);
        set_req(0, 1'b1, 1'b0, 32'h21, 2'd0, 32'h0);
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        #1 check("cfl pulse", 64'(rsp_valid0), 64'(2'b01));
        flush = 2'b01;
        #1 check("cfl killed", 64'(rsp_valid0), 64'd0);
        @(negedge clk);
        flush = 2'b00;

        // Stall for three cycles in the middle of a 4B read
        @(negedge clk);
        set_req(0, 1'b1, 1'b0, 32'h100, 2'd2, 32'h0);
        #1 check("st ready", 64'(ready0), 64'(2'b01));
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k == 1) req_valid = '0;
            if (k == 2) rdy = 1'b0;
            if (k == 5) rdy = 1'b1;
            #1 check("st addr", 64'(ram_addr0), 64'(stall_ad[k-1]));
        end
        @(negedge clk);
        check("st tail rsp", 64'(rsp_valid0), 64'd0);
        @(negedge clk);
        check("st rsp", 64'(rsp_valid0), 64'(2'b01));
        check("st rdata", 64'(rdata0), 64'h44332211);

        // Asynchronous reset in the middle of a write
        @(negedge clk);
        set_req(0, 1'b1, 1'b1, 32'h40, 2'd2, 32'hDEADBEEF);
        @(negedge clk);
        req_valid = '0;
        check("rw wr", 64'(ram_wr0), 64'd1);
        check("rw dout", 64'(ram_dout0), 64'hEF);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rw ram_addr", 64'(ram_addr0), 64'd0);
        check("rw ram_wr", 64'(ram_wr0), 64'd0);
        check("rw ram_dout", 64'(ram_dout0), 64'd0);
        check("rw rsp_valid", 64'(rsp_valid0), 64'd0);
        check("rw rdata", 64'(rdata0), 64'd0);
        check("rw busy", 64'(busy0), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("post rst rsp", 64'(rsp_valid0), 64'd0);
            check("post rst wr", 64'(ram_wr0), 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
